// File: rtl/multicycle_datapath.sv
// Multi-cycle MIPS-style datapath: register file, immediate extender, ALU and
// operand/result latches sequenced by an FSM, with a req/ack data-memory port.
module multicycle_datapath #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned REG_N       = 32,
  parameter int unsigned MEM_TIMEOUT = 0,
  localparam int unsigned AW         = $clog2(REG_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     rs,
  input  logic [AW-1:0]     rt,
  input  logic [AW-1:0]     rd,
  input  logic [15:0]       imm,
  input  logic [1:0]        RegDst,
  input  logic              ALUSrc,
  input  logic [2:0]        ALUop,
  input  logic [1:0]        EXTop,
  input  logic              RegWrite,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [1:0]        Data,
  input  logic [DATA_W-1:0] PC_4,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ZERO,
  output logic [DATA_W-1:0] GPR_rs,
  output logic [DATA_W-1:0] offset,
  input  logic [AW-1:0]     dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int unsigned SW = $clog2(DATA_W);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [15:0] imm_v, input logic [1:0] op_v);
    logic [DATA_W-1:0] sx_v;
    sx_v = DATA_W'($signed(imm_v));
    case (op_v)
      2'd0:    ext_imm = DATA_W'(imm_v);
      2'd1:    ext_imm = sx_v;
      2'd2:    ext_imm = DATA_W'(imm_v) << (DATA_W - 16);
      2'd3:    ext_imm = sx_v << 2;
      default: ext_imm = sx_v;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] alu(input logic [DATA_W-1:0] a_v, input logic [DATA_W-1:0] b_v,
                                            input logic [2:0] op_v);
    case (op_v)
      3'd0:    alu = a_v + b_v;
      3'd1:    alu = a_v - b_v;
      3'd2:    alu = a_v & b_v;
      3'd3:    alu = a_v | b_v;
      3'd4:    alu = a_v ^ b_v;
      3'd5:    alu = {{(DATA_W-1){1'b0}}, ($signed(a_v) < $signed(b_v))};
      3'd6:    alu = {{(DATA_W-1){1'b0}}, (a_v < b_v)};
      3'd7:    alu = a_v << b_v[SW-1:0];
      default: alu = {DATA_W{1'b0}};
    endcase
  endfunction

  state_t              state_r, state_nxt_s;
  logic                timeout_s;
  logic [31:0]         cnt_r;
  logic                mem_req_r, busy_r, done_r, err_r;

  logic [AW-1:0]       rs_r, rt_r, rd_r;
  logic [15:0]         imm_r;
  logic [1:0]          regdst_r, extop_r, data_r;
  logic                alusrc_r, regwrite_r, memread_r, memwrite_r;
  logic [2:0]          aluop_r;
  logic [DATA_W-1:0]   pc4_r;

  logic [DATA_W-1:0]   a_r, b_r, offset_r, alu_out_r, mdr_r;
  logic                zero_r;
  logic [DATA_W-1:0]   gpr_r [REG_N];

  logic [AW-1:0]       dest_s;
  logic [DATA_W-1:0]   wb_data_s, alu_res_s, a_rd_s, b_rd_s;
  logic                wb_en_s;

  // Next-state logic; timeout only exists when MEM_TIMEOUT is nonzero
  always_comb begin
    state_nxt_s = state_r;
    timeout_s   = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (start) state_nxt_s = S_DECODE;
        else       state_nxt_s = S_IDLE;
      end
      S_DECODE: state_nxt_s = S_EXEC;
      S_EXEC: begin
        if (memread_r | memwrite_r) state_nxt_s = S_MEM;
        else                        state_nxt_s = S_WB;
      end
      S_MEM: begin
        if (mem_ack) begin
          state_nxt_s = S_WB;
        end else if ((MEM_TIMEOUT != 32'd0) && (cnt_r == MEM_TIMEOUT - 32'd1)) begin
          state_nxt_s = S_IDLE;
          timeout_s   = 1'b1;
        end else begin
          state_nxt_s = S_MEM;
        end
      end
      S_WB:    state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Register-file reads, ALU result, destination and write-back selection
  always_comb begin
    if (rs_r == {AW{1'b0}}) a_rd_s = {DATA_W{1'b0}};
    else                    a_rd_s = gpr_r[rs_r];
    if (rt_r == {AW{1'b0}}) b_rd_s = {DATA_W{1'b0}};
    else                    b_rd_s = gpr_r[rt_r];
    if (dbg_addr == {AW{1'b0}}) dbg_data = {DATA_W{1'b0}};
    else                        dbg_data = gpr_r[dbg_addr];
    if (alusrc_r) alu_res_s = alu(a_r, offset_r, aluop_r);
    else          alu_res_s = alu(a_r, b_r, aluop_r);
    case (regdst_r)
      2'd1:    dest_s = rt_r;
      2'd2:    dest_s = AW'(REG_N - 1);
      default: dest_s = rd_r;
    endcase
    case (data_r)
      2'd0:    wb_data_s = alu_out_r;
      2'd1:    wb_data_s = mdr_r;
      2'd2:    wb_data_s = offset_r;
      2'd3:    wb_data_s = pc4_r;
      default: wb_data_s = alu_out_r;
    endcase
    wb_en_s = (state_r == S_WB) && regwrite_r && (dest_s != {AW{1'b0}});
  end

  // State register, MEM wait counter and registered status outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      cnt_r     <= 32'd0;
      mem_req_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= (state_r == S_MEM) ? cnt_r + 32'd1 : 32'd0;
      mem_req_r <= (state_nxt_s == S_MEM);
      busy_r    <= (state_nxt_s != S_IDLE);
      done_r    <= (state_nxt_s == S_WB);
      err_r     <= timeout_s;
    end
  end

  // Command capture at the accepting edge so inputs may change afterwards
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rs_r <= {AW{1'b0}}; rt_r <= {AW{1'b0}}; rd_r <= {AW{1'b0}};
      imm_r <= 16'd0; regdst_r <= 2'd0; extop_r <= 2'd0; data_r <= 2'd0;
      alusrc_r <= 1'b0; regwrite_r <= 1'b0; memread_r <= 1'b0; memwrite_r <= 1'b0;
      aluop_r <= 3'd0; pc4_r <= {DATA_W{1'b0}};
    end else if ((state_r == S_IDLE) && start) begin
      rs_r <= rs; rt_r <= rt; rd_r <= rd;
      imm_r <= imm; regdst_r <= RegDst; extop_r <= EXTop; data_r <= Data;
      alusrc_r <= ALUSrc; regwrite_r <= RegWrite; memread_r <= MemRead; memwrite_r <= MemWrite;
      aluop_r <= ALUop; pc4_r <= PC_4;
    end else begin
      pc4_r <= pc4_r;
    end
  end

  // Operand, result and memory-data latches
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_r       <= {DATA_W{1'b0}};
      b_r       <= {DATA_W{1'b0}};
      offset_r  <= {DATA_W{1'b0}};
      alu_out_r <= {DATA_W{1'b0}};
      mdr_r     <= {DATA_W{1'b0}};
      zero_r    <= 1'b0;
    end else begin
      if (state_r == S_DECODE) begin
        a_r      <= a_rd_s;
        b_r      <= b_rd_s;
        offset_r <= ext_imm(imm_r, extop_r);
      end
      if (state_r == S_EXEC) begin
        alu_out_r <= alu_res_s;
        zero_r    <= (alu_res_s == {DATA_W{1'b0}});
      end
      if ((state_r == S_MEM) && mem_ack && !memwrite_r) begin
        mdr_r <= mem_rdata;
      end
    end
  end

  // Register file; entry 0 is never written so it stays zero
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(REG_N); i++) gpr_r[i] <= {DATA_W{1'b0}};
    end else if (wb_en_s) begin
      gpr_r[dest_s] <= wb_data_s;
    end
  end

  assign mem_req   = mem_req_r;
  assign mem_we    = memwrite_r;
  assign mem_addr  = alu_out_r;
  assign mem_wdata = b_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;
  assign ZERO      = zero_r;
  assign GPR_rs    = a_r;
  assign offset    = offset_r;

endmodule

// File: tb/tb_multicycle_datapath.sv
// Directed self-checking bench for multicycle_datapath (32-bit, 32 GPRs, MEM_TIMEOUT=4).
module tb_multicycle_datapath;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [4:0]  rs, rt, rd, dbg_addr;
  logic [15:0] imm;
  logic [1:0]  RegDst, EXTop, Data;
  logic        ALUSrc, RegWrite, MemRead, MemWrite;
  logic [2:0]  ALUop;
  logic [31:0] PC_4, mem_addr, mem_wdata, mem_rdata, GPR_rs, offset, dbg_data;
  logic        mem_req, mem_we, mem_ack, busy, done, err, ZERO;

  int          n_pass = 0, n_total = 0;
  int          lat, err_cyc, req_cyc;
  bit          addr_ok;
  logic [31:0] addr_seen, wdata_seen;
  logic        we_seen;
  logic [31:0] mem_model [logic [31:0]];

  multicycle_datapath #(.DATA_W(32), .REG_N(32), .MEM_TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .rs(rs), .rt(rt), .rd(rd), .imm(imm),
    .RegDst(RegDst), .ALUSrc(ALUSrc), .ALUop(ALUop), .EXTop(EXTop), .RegWrite(RegWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .Data(Data), .PC_4(PC_4),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .busy(busy), .done(done), .err(err),
    .ZERO(ZERO), .GPR_rs(GPR_rs), .offset(offset), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // Present a command for one accepting edge, then scramble every field
  task automatic issue(input logic [4:0] rs_v, input logic [4:0] rt_v, input logic [4:0] rd_v,
                       input logic [15:0] imm_v, input logic [1:0] regdst_v, input logic alusrc_v,
                       input logic [2:0] aluop_v, input logic [1:0] extop_v, input logic regwrite_v,
                       input logic memread_v, input logic memwrite_v, input logic [1:0] data_v);
    @(negedge clk);
    rs = rs_v; rt = rt_v; rd = rd_v; imm = imm_v; RegDst = regdst_v; ALUSrc = alusrc_v;
    ALUop = aluop_v; EXTop = extop_v; RegWrite = regwrite_v; MemRead = memread_v;
    MemWrite = memwrite_v; Data = data_v; PC_4 = 32'h0000_4004; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    rs = ~rs_v; rt = ~rt_v; rd = ~rd_v; imm = ~imm_v; RegDst = ~regdst_v; ALUSrc = ~alusrc_v;
    ALUop = ~aluop_v; EXTop = ~extop_v; RegWrite = ~regwrite_v; MemRead = ~memread_v;
    MemWrite = ~memwrite_v; Data = ~data_v; PC_4 = 32'hFFFF_FFFF;
  endtask

  // Follow a command until done or err (bounded); memory acks after ack_wait MEM cycles (-1 = never)
  task automatic run(input int ack_wait);
    int mc;
    mc = 0; lat = 0; err_cyc = 0; req_cyc = 0; addr_ok = 1'b1;
    for (int cyc = 1; cyc <= 40 && lat == 0 && err_cyc == 0; cyc++) begin
      @(negedge clk);
      if (mem_req) begin
        if (mc == 0) begin
          addr_seen = mem_addr; wdata_seen = mem_wdata; we_seen = mem_we;
        end else if (mem_addr !== addr_seen || mem_wdata !== wdata_seen || mem_we !== we_seen) begin
          addr_ok = 1'b0;
        end
        req_cyc++;
        if (mc == ack_wait) begin
          mem_ack = 1'b1;
          mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 32'hDEAD_BEEF;
          if (mem_we) mem_model[mem_addr] = mem_wdata;
        end else begin
          mem_ack = 1'b0;
        end
        mc++;
      end else begin
        mem_ack = 1'b0;
      end
      if (done) lat = cyc;
      if (err) err_cyc = cyc;
    end
    mem_ack = 1'b0;
  endtask

  task automatic alui(input logic [4:0] rd_v, input logic [15:0] imm_v, input logic [1:0] extop_v);
    issue(5'd0, 5'd0, rd_v, imm_v, 2'd0, 1'b1, 3'd0, extop_v, 1'b1, 1'b0, 1'b0, 2'd0);
    run(-1);
  endtask

  task automatic peek(input logic [4:0] a);
    @(negedge clk);
    dbg_addr = a;
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_total++; if ({busy, done, err, mem_req} !== 4'b0000) $display("FAIL reset_status: got %b want 0000", {busy, done, err, mem_req}); else n_pass++;
    n_total++; if ({ZERO, GPR_rs, offset} !== 65'd0) $display("FAIL reset_latches: ZERO=%b GPR_rs=%h offset=%h want 0", ZERO, GPR_rs, offset); else n_pass++;
    @(negedge clk); reset = 1'b1;
    peek(5'd1);
    n_total++; if (dbg_data !== 32'd0) $display("FAIL reset_gpr1: got %h want 0", dbg_data); else n_pass++;
  endtask

  task automatic test_add;
    alui(5'd1, 16'd5, 2'd1);
    alui(5'd2, 16'd7, 2'd1);
    issue(5'd1, 5'd2, 5'd3, 16'h0000, 2'd0, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    run(-1);
    n_total++; if (lat !== 3) $display("FAIL add_latency: got %0d want 3", lat); else n_pass++;
    n_total++; if (ZERO !== 1'b0 || GPR_rs !== 32'd5) $display("FAIL add_flags: ZERO=%b GPR_rs=%h want 0/5", ZERO, GPR_rs); else n_pass++;
    peek(5'd3);
    n_total++; if (dbg_data !== 32'd12) $display("FAIL add_result: got %h want 0000000c", dbg_data); else n_pass++;
  endtask

  task automatic test_sub_slt;
    alui(5'd1, 16'h1234, 2'd0);
    alui(5'd2, 16'h1234, 2'd0);
    issue(5'd1, 5'd2, 5'd5, 16'h0000, 2'd0, 1'b0, 3'd1, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    run(-1);
    n_total++; if (ZERO !== 1'b1) $display("FAIL sub_zero: got %b want 1", ZERO); else n_pass++;
    alui(5'd6, 16'hFFFF, 2'd1);
    alui(5'd7, 16'h0001, 2'd1);
    issue(5'd6, 5'd7, 5'd8, 16'h0000, 2'd0, 1'b0, 3'd5, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    run(-1);
    n_total++; if (ZERO !== 1'b0) $display("FAIL slt_zero: got %b want 0", ZERO); else n_pass++;
    peek(5'd8);
    n_total++; if (dbg_data !== 32'd1) $display("FAIL slt_signed: got %h want 00000001", dbg_data); else n_pass++;
    issue(5'd6, 5'd7, 5'd9, 16'h0000, 2'd0, 1'b0, 3'd6, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    run(-1);
    n_total++; if (ZERO !== 1'b1) $display("FAIL sltu_zero: got %b want 1", ZERO); else n_pass++;
    peek(5'd9);
    n_total++; if (dbg_data !== 32'd0) $display("FAIL sltu_unsigned: got %h want 0", dbg_data); else n_pass++;
  endtask

  task automatic test_ext_shift_link;
    issue(5'd0, 5'd0, 5'd10, 16'hABCD, 2'd0, 1'b1, 3'd3, 2'd2, 1'b1, 1'b0, 1'b0, 2'd2);
    run(-1);
    n_total++; if (offset !== 32'hABCD_0000) $display("FAIL ext_lui_offset: got %h want abcd0000", offset); else n_pass++;
    peek(5'd10);
    n_total++; if (dbg_data !== 32'hABCD_0000) $display("FAIL ext_lui_wb: got %h want abcd0000", dbg_data); else n_pass++;
    alui(5'd11, 16'h8001, 2'd3);
    peek(5'd11);
    n_total++; if (dbg_data !== 32'hFFFE_0004) $display("FAIL ext_sx_shl2: got %h want fffe0004", dbg_data); else n_pass++;
    issue(5'd7, 5'd0, 5'd12, 16'd4, 2'd0, 1'b1, 3'd7, 2'd0, 1'b1, 1'b0, 1'b0, 2'd0);
    run(-1);
    peek(5'd12);
    n_total++; if (dbg_data !== 32'd16) $display("FAIL sll: got %h want 00000010", dbg_data); else n_pass++;
    issue(5'd0, 5'd0, 5'd3, 16'd0, 2'd2, 1'b0, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd3);
    run(-1);
    peek(5'd31);
    n_total++; if (dbg_data !== 32'h0000_4004) $display("FAIL link_r31: got %h want 00004004", dbg_data); else n_pass++;
  endtask

  task automatic test_mem;
    alui(5'd2, 16'h5A5A, 2'd0);
    issue(5'd1, 5'd2, 5'd0, 16'd4, 2'd0, 1'b1, 3'd0, 2'd1, 1'b0, 1'b0, 1'b1, 2'd0);
    run(2);
    n_total++; if (lat !== 6) $display("FAIL store_latency: got %0d want 6", lat); else n_pass++;
    n_total++; if (req_cyc !== 3 || addr_ok !== 1'b1) $display("FAIL store_req_hold: cycles=%0d stable=%b want 3/1", req_cyc, addr_ok); else n_pass++;
    n_total++; if (addr_seen !== 32'h1238 || wdata_seen !== 32'h5A5A || we_seen !== 1'b1)
      $display("FAIL store_bus: addr=%h wdata=%h we=%b want 00001238/00005a5a/1", addr_seen, wdata_seen, we_seen); else n_pass++;
    issue(5'd1, 5'd4, 5'd0, 16'd4, 2'd1, 1'b1, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1);
    run(0);
    n_total++; if (lat !== 4 || we_seen !== 1'b0) $display("FAIL load_latency: got %0d we=%b want 4/0", lat, we_seen); else n_pass++;
    peek(5'd4);
    n_total++; if (dbg_data !== 32'h5A5A) $display("FAIL load_data: got %h want 00005a5a", dbg_data); else n_pass++;
  endtask

  task automatic test_timeout;
    int dones;
    dones = 0;
    issue(5'd1, 5'd13, 5'd0, 16'd8, 2'd1, 1'b1, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1);
    run(-1);
    n_total++; if (err_cyc !== 7 || req_cyc !== 4) $display("FAIL timeout_err: err cycle %0d req cycles %0d want 7/4", err_cyc, req_cyc); else n_pass++;
    n_total++; if (busy !== 1'b0 || lat !== 0) $display("FAIL timeout_idle: busy=%b done_cycle=%0d want 0/0", busy, lat); else n_pass++;
    @(negedge clk);
    n_total++; if (err !== 1'b0) $display("FAIL timeout_pulse: got %b want 0", err); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (done) dones++;
    end
    n_total++; if (dones !== 0) $display("FAIL timeout_no_done: got %0d want 0", dones); else n_pass++;
    peek(5'd13);
    n_total++; if (dbg_data !== 32'd0) $display("FAIL timeout_no_write: got %h want 0", dbg_data); else n_pass++;
  endtask

  task automatic test_reset_mid_mem;
    int nz;
    nz = 0;
    issue(5'd1, 5'd14, 5'd0, 16'd4, 2'd1, 1'b1, 3'd0, 2'd1, 1'b1, 1'b1, 1'b0, 2'd1);
    repeat (3) @(negedge clk);
    n_total++; if (mem_req !== 1'b1) $display("FAIL rst_pre_mem: got %b want 1", mem_req); else n_pass++;
    #2 reset = 1'b0;
    #1;
    n_total++; if (mem_req !== 1'b0 || busy !== 1'b0) $display("FAIL rst_async: mem_req=%b busy=%b want 0/0", mem_req, busy); else n_pass++;
    @(negedge clk); reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      if (dbg_data !== 32'd0) nz++;
    end
    n_total++; if (nz !== 0) $display("FAIL rst_gprs: nonzero regs %0d want 0", nz); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int dones;
    dones = 0;
    alui(5'd0, 16'h0055, 2'd0);
    n_total++; if (lat !== 3) $display("FAIL r0_done: got %0d want 3", lat); else n_pass++;
    peek(5'd0);
    n_total++; if (dbg_data !== 32'd0) $display("FAIL r0_write: got %h want 0", dbg_data); else n_pass++;
    issue(5'd0, 5'd0, 5'd11, 16'h0077, 2'd0, 1'b1, 3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 2'd2);
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      if (done) dones++;
      start = (cyc < 3); rd = 5'd12; imm = 16'h0099; RegDst = 2'd0; RegWrite = 1'b1;
      MemRead = 1'b0; MemWrite = 1'b0; Data = 2'd2;
    end
    n_total++; if (dones !== 1) $display("FAIL busy_start_done: got %0d want 1", dones); else n_pass++;
    peek(5'd11);
    n_total++; if (dbg_data !== 32'h77) $display("FAIL busy_first_cmd: got %h want 00000077", dbg_data); else n_pass++;
    peek(5'd12);
    n_total++; if (dbg_data !== 32'd0) $display("FAIL busy_start_ignored: got %h want 0", dbg_data); else n_pass++;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0; dbg_addr = 5'd0;
    rs = 5'd0; rt = 5'd0; rd = 5'd0; imm = 16'd0; RegDst = 2'd0; ALUSrc = 1'b0; ALUop = 3'd0;
    EXTop = 2'd0; RegWrite = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Data = 2'd0; PC_4 = 32'd0;
    test_reset;
    test_add;
    test_sub_slt;
    test_ext_shift_link;
    test_mem;
    test_timeout;
    test_reset_mid_mem;
    test_back_to_back;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
